// File: rtl/mem_arb_ctrl_if.sv
// ============================================================================
// Module      : mem_arb_ctrl_if
// Description : Requester, response, init-sweep and RAM-side signal bundle
//               for mem_arb_ctrl. Stats ports exist only with MEM_ARB_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arb_ctrl_if #(
    parameter int WID_MEM = 256,
    parameter int ADDR_W  = 32
);
    logic               rq0_valid;
    logic               rq0_we;
    logic [ADDR_W-1:0]  rq0_addr;
    logic [WID_MEM-1:0] rq0_wdata;
    logic               rq0_ready;
    logic               rs0_valid;
    logic [WID_MEM-1:0] rs0_rdata;
    logic               rs0_err;

    logic               rq1_valid;
    logic               rq1_we;
    logic [ADDR_W-1:0]  rq1_addr;
    logic [WID_MEM-1:0] rq1_wdata;
    logic               rq1_ready;
    logic               rs1_valid;
    logic [WID_MEM-1:0] rs1_rdata;
    logic               rs1_err;

    logic               init_start;
    logic [WID_MEM-1:0] init_value;
    logic               init_busy;
    logic               init_done;

    logic [ADDR_W-1:0]  mem_raddr;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [WID_MEM-1:0] mem_din;
    logic               mem_we;
    logic [WID_MEM-1:0] mem_dout;

`ifdef MEM_ARB_STATS_EN
    logic [15:0]        stat_gnt0;
    logic [15:0]        stat_gnt1;
`endif

    modport slave (
        input  rq0_valid, rq0_we, rq0_addr, rq0_wdata,
        output rq0_ready, rs0_valid, rs0_rdata, rs0_err,
        input  rq1_valid, rq1_we, rq1_addr, rq1_wdata,
        output rq1_ready, rs1_valid, rs1_rdata, rs1_err,
        input  init_start, init_value,
        output init_busy, init_done,
        output mem_raddr, mem_waddr, mem_din, mem_we,
        input  mem_dout
`ifdef MEM_ARB_STATS_EN
        ,
        output stat_gnt0, stat_gnt1
`endif
    );

    modport master (
        output rq0_valid, rq0_we, rq0_addr, rq0_wdata,
        input  rq0_ready, rs0_valid, rs0_rdata, rs0_err,
        output rq1_valid, rq1_we, rq1_addr, rq1_wdata,
        input  rq1_ready, rs1_valid, rs1_rdata, rs1_err,
        output init_start, init_value,
        input  init_busy, init_done,
        input  mem_raddr, mem_waddr, mem_din, mem_we,
        output mem_dout
`ifdef MEM_ARB_STATS_EN
        ,
        input  stat_gnt0, stat_gnt1
`endif
    );
endinterface

`default_nettype wire

// File: rtl/mem_arb_ctrl.sv
// ============================================================================
// Module      : mem_arb_ctrl
// Description : Round-robin two-requester controller for a simple dual-port
//               RAM with 1-cycle registered read, plus a re-init sweep.
//               Optional grant counters under macro MEM_ARB_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_ctrl #(
    parameter int WID_MEM   = 256,
    parameter int DEPTH_MEM = 64,
    parameter int ADDR_W    = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_arb_ctrl_if.slave  bus
);
    typedef enum logic {SERVE = 1'b0, INIT = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] C_DEPTH = ADDR_W'(DEPTH_MEM);
    localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DEPTH_MEM - 1);

    state_t             state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [WID_MEM-1:0] init_val_q, init_val_d;
    logic               init_done_q, init_done_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [WID_MEM-1:0] din_q, din_d;
    logic               rd1_vld_q, rd1_vld_d;
    logic               rd1_id_q, rd1_id_d;
    logic               rd1_err_q, rd1_err_d;
    logic [1:0]         rs_vld_q, rs_vld_d;
    logic               rs_err_q, rs_err_d;

    logic               serve_ok, gnt0, gnt1, g_we, g_in_range;
    logic [ADDR_W-1:0]  g_addr;
    logic [WID_MEM-1:0] g_wdata;

    // Ready is held low while reset is asserted so every output reads 0.
    always_comb begin
        serve_ok   = reset && (state_q == SERVE) && !bus.init_start;
        gnt0       = serve_ok && bus.rq0_valid && (!bus.rq1_valid || last_gnt_q);
        gnt1       = serve_ok && bus.rq1_valid && (!bus.rq0_valid || !last_gnt_q);
        g_we       = gnt1 ? bus.rq1_we    : bus.rq0_we;
        g_addr     = gnt1 ? bus.rq1_addr  : bus.rq0_addr;
        g_wdata    = gnt1 ? bus.rq1_wdata : bus.rq0_wdata;
        g_in_range = (g_addr < C_DEPTH);
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        init_val_d  = init_val_q;
        init_done_d = 1'b0;
        wr_d        = 1'b0;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        din_d       = din_q;
        rd1_vld_d   = 1'b0;
        rd1_id_d    = rd1_id_q;
        rd1_err_d   = 1'b0;
        rs_vld_d    = 2'b00;
        rs_err_d    = rd1_vld_q && rd1_err_q;

        case (state_q)
            SERVE: begin
                if (bus.init_start) begin
                    state_d    = INIT;
                    init_val_d = bus.init_value;
                    cnt_d      = '0;
                end
            end
            INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == C_LAST) begin
                    state_d     = SERVE;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            default: state_d = SERVE;
        endcase

        if (gnt0 || gnt1) begin
            last_gnt_d = gnt1;
            if (g_we) begin
                // Out-of-range writes are accepted but never reach the RAM.
                if (g_in_range) begin
                    wr_d    = 1'b1;
                    waddr_d = g_addr;
                    din_d   = g_wdata;
                end
            end else begin
                if (g_in_range) begin
                    raddr_d = g_addr;
                end
                rd1_vld_d = 1'b1;
                rd1_id_d  = gnt1;
                rd1_err_d = !g_in_range;
            end
        end

        rs_vld_d[rd1_id_q] = rd1_vld_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SERVE;
            last_gnt_q  <= 1'b1;
            cnt_q       <= '0;
            init_val_q  <= '0;
            init_done_q <= 1'b0;
            wr_q        <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            din_q       <= '0;
            rd1_vld_q   <= 1'b0;
            rd1_id_q    <= 1'b0;
            rd1_err_q   <= 1'b0;
            rs_vld_q    <= 2'b00;
            rs_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            init_val_q  <= init_val_d;
            init_done_q <= init_done_d;
            wr_q        <= wr_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            din_q       <= din_d;
            rd1_vld_q   <= rd1_vld_d;
            rd1_id_q    <= rd1_id_d;
            rd1_err_q   <= rd1_err_d;
            rs_vld_q    <= rs_vld_d;
            rs_err_q    <= rs_err_d;
        end
    end

    assign bus.rq0_ready = gnt0;
    assign bus.rq1_ready = gnt1;
    assign bus.rs0_valid = rs_vld_q[0];
    assign bus.rs1_valid = rs_vld_q[1];
    assign bus.rs0_err   = rs_vld_q[0] && rs_err_q;
    assign bus.rs1_err   = rs_vld_q[1] && rs_err_q;
    assign bus.rs0_rdata = (rs_vld_q[0] && !rs_err_q) ? bus.mem_dout : '0;
    assign bus.rs1_rdata = (rs_vld_q[1] && !rs_err_q) ? bus.mem_dout : '0;
    assign bus.init_busy = (state_q == INIT);
    assign bus.init_done = init_done_q;
    assign bus.mem_we    = wr_q || (state_q == INIT);
    assign bus.mem_waddr = (state_q == INIT) ? cnt_q : waddr_q;
    assign bus.mem_din   = (state_q == INIT) ? init_val_q : din_q;
    assign bus.mem_raddr = raddr_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat0_q, stat0_d, stat1_q, stat1_d;

    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if ((state_q == SERVE) && bus.init_start) begin
            stat0_d = '0;
            stat1_d = '0;
        end else begin
            if (gnt0 && (stat0_q != 16'hFFFF)) stat0_d = stat0_q + 16'd1;
            if (gnt1 && (stat1_q != 16'hFFFF)) stat1_d = stat1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign bus.stat_gnt0 = stat0_q;
    assign bus.stat_gnt1 = stat1_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_mem_arb_ctrl.sv
// ============================================================================
// Module      : tb_mem_arb_ctrl
// Description : Directed self-checking bench for mem_arb_ctrl with a
//               behavioural 64-word RAM (1-cycle registered read).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arb_ctrl;
    localparam int WID_MEM   = 256;
    localparam int DEPTH_MEM = 64;
    localparam int ADDR_W    = 32;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_arb_ctrl_if #(.WID_MEM(WID_MEM), .ADDR_W(ADDR_W)) bus ();

    mem_arb_ctrl #(
        .WID_MEM  (WID_MEM),
        .DEPTH_MEM(DEPTH_MEM),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WID_MEM-1:0] ram [0:DEPTH_MEM-1];

    always @(posedge clk) begin
        if (bus.mem_we && (bus.mem_waddr < DEPTH_MEM))
            ram[bus.mem_waddr[5:0]] <= bus.mem_din;
        bus.mem_dout <= (bus.mem_raddr < DEPTH_MEM) ? ram[bus.mem_raddr[5:0]] : '0;
    end

    task automatic chk(input string tag, input logic [WID_MEM-1:0] observed,
                       input logic [WID_MEM-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        bus.rq0_valid  = 1'b0; bus.rq0_we = 1'b0; bus.rq0_addr = '0; bus.rq0_wdata = '0;
        bus.rq1_valid  = 1'b0; bus.rq1_we = 1'b0; bus.rq1_addr = '0; bus.rq1_wdata = '0;
        bus.init_start = 1'b0; bus.init_value = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle_inputs();

        // Reset: outputs all zero even with a request pending
        bus.rq0_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rq0_ready", bus.rq0_ready, 0);
        chk("rst_rs0_valid", bus.rs0_valid, 0);
        chk("rst_init_busy", bus.init_busy, 0);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_mem_we",    bus.mem_we, 0);
        chk("rst_mem_waddr", bus.mem_waddr, 0);
        chk("rst_mem_raddr", bus.mem_raddr, 0);
        chk("rst_mem_din",   bus.mem_din, 0);

        // Test 1: tie on the first cycle -> rq0 write wins, rq1 read next
        @(negedge clk);
        reset = 1'b1;
        bus.rq0_valid = 1'b1; bus.rq0_we = 1'b1; bus.rq0_addr = 5; bus.rq0_wdata = {32{8'hA5}};
        bus.rq1_valid = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 5;
        #1;
        chk("t1_tie_rq0_ready", bus.rq0_ready, 1);
        chk("t1_tie_rq1_ready", bus.rq1_ready, 0);
        @(negedge clk);
        bus.rq0_valid = 1'b0;
        #1;
        chk("t1_rq1_ready", bus.rq1_ready, 1);
        chk("t1_mem_we",    bus.mem_we, 1);
        chk("t1_mem_waddr", bus.mem_waddr, 5);
        chk("t1_mem_din",   bus.mem_din, {32{8'hA5}});
        @(negedge clk);
        bus.rq1_valid = 1'b0;
        #1;
        chk("t1_mem_we_off", bus.mem_we, 0);
        chk("t1_mem_raddr",  bus.mem_raddr, 5);
        chk("t1_rs1_early",  bus.rs1_valid, 0);
        @(negedge clk);
        #1;
        chk("t1_rs1_valid", bus.rs1_valid, 1);
        chk("t1_rs1_rdata", bus.rs1_rdata, {32{8'hA5}});
        chk("t1_rs1_err",   bus.rs1_err, 0);
        chk("t1_rs0_valid", bus.rs0_valid, 0);

        // Preload addr 1 and 2 (tie again; rq1 was last, so rq0 first)
        @(negedge clk);
        bus.rq0_valid = 1'b1; bus.rq0_we = 1'b1; bus.rq0_addr = 1; bus.rq0_wdata = {32{8'h01}};
        bus.rq1_valid = 1'b1; bus.rq1_we = 1'b1; bus.rq1_addr = 2; bus.rq1_wdata = {32{8'h02}};
        #1;
        chk("pre_rq0_ready", bus.rq0_ready, 1);
        @(negedge clk);
        bus.rq0_valid = 1'b0;
        #1;
        chk("pre_rq1_ready", bus.rq1_ready, 1);

        // Test 2: both hold reads for 4 cycles; grants alternate 0,1,0,1
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.rq0_valid = (k < 4); bus.rq0_we = 1'b0; bus.rq0_addr = 1;
            bus.rq1_valid = (k < 4); bus.rq1_we = 1'b0; bus.rq1_addr = 2;
            #1;
            chk("t2_rq0_ready", bus.rq0_ready, (k < 4) && (k % 2 == 0));
            chk("t2_rq1_ready", bus.rq1_ready, (k < 4) && (k % 2 == 1));
            chk("t2_rs0_valid", bus.rs0_valid, (k >= 2) && (k % 2 == 0));
            chk("t2_rs1_valid", bus.rs1_valid, (k >= 2) && (k % 2 == 1));
            if (k >= 2 && k % 2 == 0) chk("t2_rs0_rdata", bus.rs0_rdata, {32{8'h01}});
            if (k >= 2 && k % 2 == 1) chk("t2_rs1_rdata", bus.rs1_rdata, {32{8'h02}});
        end

        // Test 3: init sweep wins over a pending rq0 read
        @(negedge clk);
        bus.init_start = 1'b1; bus.init_value = {32{8'h3C}};
        bus.rq0_valid  = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 0;
        #1;
        chk("t3_start_no_grant", bus.rq0_ready, 0);
        chk("t3_start_busy",     bus.init_busy, 0);
        for (int k = 0; k < DEPTH_MEM; k++) begin
            @(negedge clk);
            bus.init_start = 1'b0;
            #1;
            chk("t3_busy",      bus.init_busy, 1);
            chk("t3_mem_we",    bus.mem_we, 1);
            chk("t3_mem_waddr", bus.mem_waddr, k);
            chk("t3_mem_din",   bus.mem_din, {32{8'h3C}});
            chk("t3_rq0_ready", bus.rq0_ready, 0);
            chk("t3_done_early", bus.init_done, 0);
        end
        @(negedge clk);
        #1;
        chk("t3_done",      bus.init_done, 1);
        chk("t3_busy_off",  bus.init_busy, 0);
        chk("t3_rq0_grant", bus.rq0_ready, 1);
        @(negedge clk);
        bus.rq0_addr = 63;
        #1;
        chk("t3_done_pulse", bus.init_done, 0);
        chk("t3_rq0_grant2", bus.rq0_ready, 1);
        @(negedge clk);
        bus.rq0_valid = 1'b0;
        #1;
        chk("t3_rs0_a0_valid", bus.rs0_valid, 1);
        chk("t3_rs0_a0_rdata", bus.rs0_rdata, {32{8'h3C}});
        @(negedge clk);
        #1;
        chk("t3_rs0_a63_valid", bus.rs0_valid, 1);
        chk("t3_rs0_a63_rdata", bus.rs0_rdata, {32{8'h3C}});

        // Test 4: out-of-range read and write
        @(negedge clk);
        bus.rq0_valid = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 64;
        #1;
        chk("t4_rd_ready", bus.rq0_ready, 1);
        chk("t4_rs0_idle", bus.rs0_valid, 0);
        @(negedge clk);
        bus.rq0_we = 1'b1; bus.rq0_addr = 100; bus.rq0_wdata = {32{8'hFF}};
        #1;
        chk("t4_wr_ready", bus.rq0_ready, 1);
        @(negedge clk);
        bus.rq0_valid = 1'b0;
        #1;
        chk("t4_rs0_valid", bus.rs0_valid, 1);
        chk("t4_rs0_err",   bus.rs0_err, 1);
        chk("t4_rs0_rdata", bus.rs0_rdata, 0);
        chk("t4_mem_we",    bus.mem_we, 0);
        @(negedge clk);
        #1;
        chk("t4_rs0_done",  bus.rs0_valid, 0);
        chk("t4_mem_we2",   bus.mem_we, 0);

        // Test 5: write addr 30, start a sweep, reset it at count 20
        @(negedge clk);
        bus.rq1_valid = 1'b1; bus.rq1_we = 1'b1; bus.rq1_addr = 30; bus.rq1_wdata = {32{8'h77}};
        #1;
        chk("t5_wr_ready", bus.rq1_ready, 1);
        @(negedge clk);
        bus.rq1_valid  = 1'b0;
        bus.init_start = 1'b1; bus.init_value = {32{8'h11}};
        #1;
        chk("t5_mem_we",    bus.mem_we, 1);
        chk("t5_mem_waddr", bus.mem_waddr, 30);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            bus.init_start = 1'b0;
            #1;
            chk("t5_sweep_waddr", bus.mem_waddr, k);
        end
        reset = 1'b0;
        #1;
        chk("t5_rst_busy",  bus.init_busy, 0);
        chk("t5_rst_we",    bus.mem_we, 0);
        chk("t5_rst_waddr", bus.mem_waddr, 0);
        chk("t5_rst_din",   bus.mem_din, 0);
        chk("t5_rst_raddr", bus.mem_raddr, 0);
        chk("t5_rst_done",  bus.init_done, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.rq0_valid = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 30;
        #1;
        chk("t5_serve_busy",  bus.init_busy, 0);
        chk("t5_serve_ready", bus.rq0_ready, 1);
        @(negedge clk);
        bus.rq0_addr = 5;
        #1;
        chk("t5_ready_a5", bus.rq0_ready, 1);
        @(negedge clk);
        bus.rq0_valid = 1'b0;
        #1;
        chk("t5_rs0_a30_valid", bus.rs0_valid, 1);
        chk("t5_rs0_a30_rdata", bus.rs0_rdata, {32{8'h77}});
        @(negedge clk);
        #1;
        chk("t5_rs0_a5_rdata", bus.rs0_rdata, {32{8'h11}});

`ifdef MEM_ARB_STATS_EN
        // Stats: reset clears, 5 grants to rq0 and 3 to rq1, init clears
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("st_rst_gnt0", bus.stat_gnt0, 0);
        chk("st_rst_gnt1", bus.stat_gnt1, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.rq0_valid = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 0;
            bus.rq1_valid = (k < 6); bus.rq1_we = 1'b0; bus.rq1_addr = 0;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("st_gnt0", bus.stat_gnt0, 5);
        chk("st_gnt1", bus.stat_gnt1, 3);
        @(negedge clk);
        bus.init_start = 1'b1;
        @(negedge clk);
        bus.init_start = 1'b0;
        #1;
        chk("st_clr_gnt0", bus.stat_gnt0, 0);
        chk("st_clr_gnt1", bus.stat_gnt1, 0);
        repeat (DEPTH_MEM) @(negedge clk);
        #1;
        chk("st_init_done", bus.init_done, 1);
`endif

        idle_inputs();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
